// File: rtl/nes_bus_pkg.sv
// Shared NES bus definitions: DMA FSM state encoding and default register addresses.
package nes_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_e;

    localparam logic [15:0] DMA_REG_ADDR_DEFAULT  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR_DEFAULT = 16'h2004;

endpackage

// File: rtl/oam_dma_controller.sv
// OAM DMA: a CPU write to the DMA register halts the CPU and copies one 256-byte page
// into the PPU OAM data port, one read/write pair per pair of CPU bus cycles.
module oam_dma_controller
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEFAULT,
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rw,
    input  logic [7:0]  bus_rdata,
    output logic        cpu_halt,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_rw,
    output logic        dma_active
);

    dma_state_e state_q, state_d;
    logic       parity_q, parity_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] latch_q, latch_d;

    always_comb begin
        state_d  = state_q;
        parity_d = parity_q;
        page_d   = page_q;
        idx_d    = idx_q;
        latch_d  = latch_q;
        if (cpu_ce) begin
            parity_d = ~parity_q;
            case (state_q)
                ST_IDLE: begin
                    if (!cpu_rw && (cpu_addr == DMA_REG_ADDR)) begin
                        page_d  = cpu_wdata;
                        idx_d   = 8'd0;
                        state_d = ST_HALT;
                    end
                end
                // An extra ALIGN cycle keeps every READ on an even (parity 0) cycle.
                ST_HALT:  state_d = parity_q ? ST_READ : ST_ALIGN;
                ST_ALIGN: state_d = ST_READ;
                ST_READ: begin
                    latch_d = bus_rdata;
                    state_d = ST_WRITE;
                end
                ST_WRITE: begin
                    if (idx_q == 8'hFF) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = ST_READ;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            parity_q <= 1'b0;
            page_q   <= 8'd0;
            idx_q    <= 8'd0;
            latch_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            latch_q  <= latch_d;
        end
    end

    // While halted the CPU still drives the bus, but only as a dummy read.
    always_comb begin
        bus_addr  = cpu_addr;
        bus_wdata = cpu_wdata;
        bus_rw    = cpu_rw;
        case (state_q)
            ST_HALT, ST_ALIGN: bus_rw = 1'b1;
            ST_READ: begin
                bus_addr = {page_q, idx_q};
                bus_rw   = 1'b1;
            end
            ST_WRITE: begin
                bus_addr  = OAM_DATA_ADDR;
                bus_wdata = latch_q;
                bus_rw    = 1'b0;
            end
            default: ;
        endcase
    end

    assign cpu_halt   = (state_q != ST_IDLE);
    assign dma_active = (state_q == ST_READ) || (state_q == ST_WRITE);

endmodule

// File: tb/tb_oam_dma_controller.sv
// Scoreboard bench for oam_dma_controller: stimulus queues expected reads, OAM writes and
// halt lengths; a negedge monitor compares them whenever the DUT is on a cpu_ce cycle.
module tb_oam_dma_controller;
    import nes_bus_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_ce;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rw;
    logic [7:0]  bus_rdata;
    logic        cpu_halt;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_rw;
    logic        dma_active;

    always #5 clock = ~clock;

    // Memory model: byte at offset n of any page holds n ^ 8'h5A.
    assign bus_rdata = bus_addr[7:0] ^ 8'h5A;

    oam_dma_controller dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_ce     (cpu_ce),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rw     (cpu_rw),
        .bus_rdata  (bus_rdata),
        .cpu_halt   (cpu_halt),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rw     (bus_rw),
        .dma_active (dma_active)
    );

    typedef struct {
        int lead;
        int total;
    } halt_exp_t;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  wq[$];
    logic [15:0] rq[$];
    halt_exp_t   hq[$];
    bit          tb_par = 1'b0;
    int          gap = 0;
    bit          chk_stable = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endtask

    // Monitor: acts on every clock whose rising edge will be a cpu_ce edge.
    int        halt_cnt = 0;
    int        lead_cnt = 0;
    bit        seen_read = 1'b0;
    halt_exp_t hx;
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                tb_par    = 1'b0;
                halt_cnt  = 0;
                lead_cnt  = 0;
                seen_read = 1'b0;
            end else if (cpu_ce) begin
                if (cpu_halt) begin
                    halt_cnt++;
                    if (dma_active && bus_rw) begin
                        seen_read = 1'b1;
                        if (rq.size() == 0) flag("unexpected_read", bus_addr);
                        else begin
                            check("read_addr", bus_addr, rq.pop_front());
                            check("read_parity", tb_par, 0);
                        end
                    end else if (dma_active) begin
                        check("write_addr", bus_addr, 16'h2004);
                        if (wq.size() == 0) flag("unexpected_write", bus_wdata);
                        else check("write_data", bus_wdata, wq.pop_front());
                    end else if (!seen_read) begin
                        lead_cnt++;
                    end
                end else if (halt_cnt > 0) begin
                    if (hq.size() == 0) flag("unexpected_halt", halt_cnt);
                    else begin
                        hx = hq.pop_front();
                        check("halt_cycles", halt_cnt, hx.total);
                        check("lead_cycles", lead_cnt, hx.lead);
                    end
                    halt_cnt  = 0;
                    lead_cnt  = 0;
                    seen_read = 1'b0;
                end
                tb_par = ~tb_par;
            end
        end
    end

    task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
        logic [26:0] snap;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_rw    = rw;
        cpu_ce    = 1'b0;
        #1;
        snap = {cpu_halt, dma_active, bus_rw, bus_addr, bus_wdata};
        for (int i = 0; i < gap; i++) begin
            @(posedge clock);
            #1;
        end
        if (chk_stable && gap > 0)
            check("gap_hold", {cpu_halt, dma_active, bus_rw, bus_addr, bus_wdata}, snap);
        cpu_ce = 1'b1;
        @(posedge clock);
        #1;
        cpu_ce = 1'b0;
    endtask

    task automatic idle_cycle();
        cpu_cycle(16'h0000, 8'h00, 1'b1);
    endtask

    task automatic set_par(input bit p);
        if (tb_par != p) idle_cycle();
    endtask

    // Parity 0 at the trigger edge: HALT lands on parity 1, READ follows directly.
    task automatic trigger(input logic [7:0] page);
        halt_exp_t h;
        h.lead  = (tb_par == 1'b0) ? 1 : 2;
        h.total = h.lead + 512;
        hq.push_back(h);
        for (int i = 0; i < 256; i++) begin
            rq.push_back({page, 8'(i)});
            wq.push_back(8'(i) ^ 8'h5A);
        end
        cpu_cycle(16'h4014, page, 1'b0);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((cpu_halt || hq.size() != 0) && n < 2000) begin
            idle_cycle();
            n++;
        end
        check({name, "_done_in_time"}, n < 2000, 1);
        check({name, "_reads_left"}, rq.size(), 0);
        check({name, "_writes_left"}, wq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset wins over a simultaneous trigger write.
        reset     = 1'b1;
        cpu_ce    = 1'b1;
        cpu_addr  = 16'h4014;
        cpu_wdata = 8'h77;
        cpu_rw    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset     = 1'b0;
        cpu_ce    = 1'b0;
        cpu_addr  = 16'h1234;
        cpu_wdata = 8'hAB;
        #1;
        check("reset_halt", cpu_halt, 0);
        check("reset_active", dma_active, 0);
        check("pass_addr", bus_addr, 16'h1234);
        check("pass_wdata", bus_wdata, 8'hAB);
        check("pass_rw_w", bus_rw, 0);
        cpu_rw   = 1'b1;
        cpu_addr = 16'h0300;
        #1;
        check("pass_rw_r", bus_rw, 1);
        check("pass_addr_r", bus_addr, 16'h0300);
        idle_cycle();
        idle_cycle();
        check("idle_no_halt", cpu_halt, 0);

        // Trigger at parity 0: 513 halted cycles, HALT then READ.
        set_par(1'b0);
        trigger(8'h02);
        cpu_addr = 16'h1111;
        cpu_rw   = 1'b0;
        #1;
        check("halt_halted", cpu_halt, 1);
        check("halt_not_active", dma_active, 0);
        check("halt_dummy_rw", bus_rw, 1);
        check("halt_addr", bus_addr, 16'h1111);
        wait_done("dma_p0");

        // Trigger at parity 1: ALIGN inserted, 514 halted cycles.
        set_par(1'b1);
        trigger(8'h02);
        wait_done("dma_p1");

        // Slow cpu_ce: outputs hold between pulses; trigger write mid-DMA ignored.
        gap = 11;
        set_par(1'b0);
        trigger(8'h05);
        chk_stable = 1'b1;
        repeat (3) idle_cycle();
        cpu_cycle(16'h4014, 8'h33, 1'b0);
        repeat (3) idle_cycle();
        chk_stable = 1'b0;
        wait_done("dma_gap");
        gap = 0;

        // Top page: last read at 16'hFFFF, then idle with no extra write.
        trigger(8'hFF);
        wait_done("dma_ff");
        repeat (4) idle_cycle();

        // Trigger on the cpu_ce that ends the final WRITE is ignored.
        set_par(1'b0);
        trigger(8'h07);
        n = 0;
        while (!(wq.size() == 1 && dma_active && !bus_rw) && n < 1000) begin
            idle_cycle();
            n++;
        end
        check("last_write_reached", n < 1000, 1);
        cpu_cycle(16'h4014, 8'h09, 1'b0);
        check("late_trigger_ignored", cpu_halt, 0);
        wait_done("dma_late");
        repeat (3) idle_cycle();
        check("late_still_idle", cpu_halt, 0);

        // Reset during WRITE of idx 8'h40 aborts the transfer.
        trigger(8'h03);
        n = 0;
        while (!(wq.size() == 192 && dma_active && !bus_rw) && n < 1000) begin
            idle_cycle();
            n++;
        end
        check("abort_point_reached", n < 1000, 1);
        reset  = 1'b1;
        cpu_ce = 1'b1;
        @(posedge clock);
        #1;
        reset  = 1'b0;
        cpu_ce = 1'b0;
        #1;
        check("abort_halt", cpu_halt, 0);
        check("abort_active", dma_active, 0);
        check("abort_writes_done", wq.size(), 192);
        wq.delete();
        rq.delete();
        hq.delete();
        repeat (20) idle_cycle();
        check("abort_stays_idle", cpu_halt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
